// File: rtl/mux41_rr_arbiter.sv
// rtl/mux41_rr_arbiter.sv - round-robin arbiter driving the shared 4:1 mux selects
// Grants one of four requesters at a time with a bounded hold window for fairness.
module mux41_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  output logic [3:0]        gnt,
  output logic [1:0]        sel,
  output logic              busy,
  output logic              switch,
  output logic [HOLD_W-1:0] hold_cnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, state_n;
  logic [3:0]        gnt_n;
  logic [1:0]        sel_n;
  logic [1:0]        last, last_n;
  logic              switch_n;
  logic [HOLD_W-1:0] hold_n;

  logic [3:0]        cand;
  logic [1:0]        pick;
  logic [1:0]        idx;
  logic              pick_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      sel      <= 2'b00;
      last     <= 2'd3;
      switch   <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      sel      <= sel_n;
      last     <= last_n;
      switch   <= switch_n;
      hold_cnt <= hold_n;
    end
  end

  assign busy = |gnt;

  // The current owner never competes against itself when rotating away.
  always_comb begin
    cand       = (state == GRANT) ? (req & ~gnt) : req;
    pick       = 2'd0;
    idx        = 2'd0;
    pick_valid = |cand;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (cand[idx]) pick = idx;
    end
  end

  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    sel_n    = sel;
    last_n   = last;
    switch_n = 1'b0;
    hold_n   = hold_cnt;

    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n  = GRANT;
          gnt_n    = 4'b0001 << pick;
          sel_n    = pick;
          last_n   = pick;
          hold_n   = HOLD_W'(1);
          switch_n = 1'b1;
        end
      end
      GRANT: begin
        if (!req[sel] || hold_cnt == HOLD_W'(MAX_HOLD)) begin
          if (pick_valid) begin
            gnt_n    = 4'b0001 << pick;
            sel_n    = pick;
            last_n   = pick;
            hold_n   = HOLD_W'(1);
            switch_n = 1'b1;
          end else if (!req[sel]) begin
            state_n = IDLE;
            gnt_n   = 4'b0000;
            hold_n  = '0;
          end else begin
            hold_n = HOLD_W'(1);
          end
        end else begin
          hold_n = hold_cnt + HOLD_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// tb/tb_mux41_rr_arbiter.sv - scoreboard bench for mux41_rr_arbiter
module tb_mux41_rr_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int HOLD_W   = 4;

  logic              clk;
  logic              rst;
  logic [3:0]        req;
  logic [3:0]        gnt;
  logic [1:0]        sel;
  logic              busy;
  logic              switch;
  logic [HOLD_W-1:0] hold_cnt;

  logic [3:0] mux_in;
  logic       mux_out;

  int total;
  int bad;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       sw;
    logic [3:0] hold;
    logic       mo;
  } exp_t;

  exp_t exp_q[$];

  // reference model state
  int m_owner;
  int m_last;
  int m_held;
  int m_sel;

  mux41_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .sel      (sel),
    .busy     (busy),
    .switch   (switch),
    .hold_cnt (hold_cnt)
  );

  assign mux_out = mux_in[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] rq);
    exp_t e;
    int   nxt;
    int   sw;
    @(negedge clk);
    rst = r;
    req = rq;
    sw  = 0;
    if (r) begin
      m_owner = -1;
      m_last  = 3;
      m_held  = 0;
      m_sel   = 0;
    end else begin
      nxt = -1;
      for (int k = 1; k <= 4; k++) begin
        int j;
        j = (m_last + k) % 4;
        if (nxt < 0 && rq[j] && j != m_owner) nxt = j;
      end
      if (m_owner < 0 || !rq[m_owner] || m_held == MAX_HOLD) begin
        if (nxt >= 0) begin
          m_owner = nxt;
          m_last  = nxt;
          m_sel   = nxt;
          m_held  = 1;
          sw      = 1;
        end else if (m_owner >= 0 && !rq[m_owner]) begin
          m_owner = -1;
          m_held  = 0;
        end else if (m_owner >= 0) begin
          m_held = 1;
        end
      end else begin
        m_held = m_held + 1;
      end
    end
    e.gnt  = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    e.sel  = 2'(m_sel);
    e.busy = (m_owner >= 0);
    e.sw   = 1'(sw);
    e.hold = 4'(m_held);
    e.mo   = mux_in[m_sel];
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt", int'(gnt), int'(e.gnt));
        chk("sel", int'(sel), int'(e.sel));
        chk("busy", int'(busy), int'(e.busy));
        chk("switch", int'(switch), int'(e.sw));
        chk("hold_cnt", int'(hold_cnt), int'(e.hold));
        if (e.busy) chk("mux_out", int'(mux_out), int'(e.mo));
      end
    end
  end

  initial begin : stimulus
    logic [3:0] rq;
    int         guard;
    total   = 0;
    bad     = 0;
    mux_in  = 4'b0101;
    rst     = 1'b1;
    req     = 4'b0000;
    m_owner = -1;
    m_last  = 3;
    m_held  = 0;
    m_sel   = 0;

    repeat (2) step(1'b1, 4'b1111);
    repeat (2) step(1'b0, 4'b0100);
    repeat (2) step(1'b0, 4'b0000);
    repeat (17) step(1'b0, 4'b1111);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b0100);
    step(1'b0, 4'b0000);
    repeat (2) step(1'b0, 4'b0101);
    step(1'b0, 4'b0000);
    repeat (10) step(1'b0, 4'b0010);
    step(1'b0, 4'b0000);
    repeat (2) step(1'b0, 4'b1000);
    step(1'b1, 4'b1000);
    repeat (2) step(1'b0, 4'b1001);
    step(1'b0, 4'b0110);
    step(1'b0, 4'b1001);

    rq = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(3) == 0) rq[b] = ~rq[b];
      step(($urandom_range(49) == 0), rq);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
